pwd_lock_ctrl: RTL and testbench

Sequencing controller for the 3-digit BCD password entry path. It receives a completed 12-bit code, compares it with a stored password and drives the lock state. It also counts failed attempts, enforces a timed lockout and runs a two-entry password change sequence. It sits between the digit-entry front end (switch/key capture, 7-segment echo) and the board LEDs/actuator.

---
 rtl/pwd_lock_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pwd_lock_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwd_lock_ctrl.sv
// Password lock sequencer: checks a 3-digit BCD code against the stored password, opens, locks out, changes password.
// Latency: code_valid at edge N -> CHECK after N -> decision (state, fail_cnt, pulses) after N+1; all outputs registered.
// Backpressure: none; code_valid arriving outside IDLE/NEW1/NEW2 (CHECK, OPEN, LOCKOUT) is dropped.
//
// Ports:
//   clock, reset       rising-edge clock; asynchronous active-high reset
//   code_in/code_valid 12-bit entered code with single-cycle strobe
//   change_req         single-cycle request to change password (OPEN only)
//   state              IDLE=0 CHECK=1 OPEN=2 LOCKOUT=3 NEW1=4 NEW2=5
//   unlocked/lockout   high exactly while state is OPEN / LOCKOUT
//   fail_cnt           consecutive failed attempts
//   ok_pulse/err_pulse one-cycle outcome strobes
module pwd_lock_ctrl #(
   parameter logic [11:0] DEFAULT_PWD = 12'h123,
   parameter int unsigned MAX_TRIES   = 3,
   parameter logic [31:0] OPEN_CYCLES = 32'd50_000_000,
   parameter logic [31:0] LOCK_CYCLES = 32'd250_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] code_in,
   input  logic        code_valid,
   input  logic        change_req,
   output logic [2:0]  state,
   output logic        unlocked,
   output logic        lockout,
   output logic [1:0]  fail_cnt,
   output logic        ok_pulse,
   output logic        err_pulse
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_OPEN    = 3'd2,
      ST_LOCKOUT = 3'd3,
      ST_NEW1    = 3'd4,
      ST_NEW2    = 3'd5
   } state_t;

   localparam logic [2:0]  MAX_T     = 3'(MAX_TRIES);
   localparam logic [31:0] OPEN_LAST = OPEN_CYCLES - 32'd1;
   localparam logic [31:0] LOCK_LAST = LOCK_CYCLES - 32'd1;

   state_t      state_q, state_nxt;
   logic [11:0] pwd_q, pwd_nxt;
   logic [11:0] cand_q, cand_nxt;
   logic [11:0] code_q, code_nxt;
   logic [31:0] timer_q, timer_nxt;
   logic [1:0]  fail_q, fail_nxt;
   logic        ok_nxt, err_nxt;
   logic        unlocked_q, lockout_q, ok_q, err_q;

   function automatic logic is_bcd(input logic [11:0] c);
      return (c[11:8] <= 4'd9) && (c[7:4] <= 4'd9) && (c[3:0] <= 4'd9);
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pwd_q      <= DEFAULT_PWD;
         cand_q     <= 12'd0;
         code_q     <= 12'd0;
         timer_q    <= 32'd0;
         fail_q     <= 2'd0;
         unlocked_q <= 1'b0;
         lockout_q  <= 1'b0;
         ok_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         pwd_q      <= pwd_nxt;
         cand_q     <= cand_nxt;
         code_q     <= code_nxt;
         timer_q    <= timer_nxt;
         fail_q     <= fail_nxt;
         // Decoded from the next state so the flags line up with state exactly.
         unlocked_q <= (state_nxt == ST_OPEN);
         lockout_q  <= (state_nxt == ST_LOCKOUT);
         ok_q       <= ok_nxt;
         err_q      <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      pwd_nxt   = pwd_q;
      cand_nxt  = cand_q;
      code_nxt  = code_q;
      timer_nxt = 32'd0;
      fail_nxt  = fail_q;
      ok_nxt    = 1'b0;
      err_nxt   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (code_valid) begin
               code_nxt  = code_in;
               state_nxt = ST_CHECK;
            end
         end

         ST_CHECK: begin
            // A non-BCD entry never matches, even if the stored value were non-BCD.
            if (is_bcd(code_q) && (code_q == pwd_q)) begin
               fail_nxt  = 2'd0;
               ok_nxt    = 1'b1;
               state_nxt = ST_OPEN;
            end else begin
               err_nxt = 1'b1;
               if (({1'b0, fail_q} + 3'd1) == MAX_T) begin
                  fail_nxt  = MAX_T[1:0];
                  state_nxt = ST_LOCKOUT;
               end else begin
                  fail_nxt  = fail_q + 2'd1;
                  state_nxt = ST_IDLE;
               end
            end
         end

         ST_OPEN: begin
            timer_nxt = timer_q + 32'd1;
            // change_req takes priority over both code_valid and the open timeout.
            if (change_req) begin
               timer_nxt = 32'd0;
               state_nxt = ST_NEW1;
            end else if (timer_q == OPEN_LAST) begin
               state_nxt = ST_IDLE;
            end
         end

         ST_NEW1: begin
            timer_nxt = timer_q + 32'd1;
            if (code_valid) begin
               if (is_bcd(code_in)) begin
                  cand_nxt  = code_in;
                  timer_nxt = 32'd0;
                  state_nxt = ST_NEW2;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end else if (timer_q == OPEN_LAST) begin
               state_nxt = ST_IDLE;
            end
         end

         ST_NEW2: begin
            timer_nxt = timer_q + 32'd1;
            if (code_valid) begin
               if (code_in == cand_q) begin
                  pwd_nxt = cand_q;
                  ok_nxt  = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
               state_nxt = ST_IDLE;
            end else if (timer_q == OPEN_LAST) begin
               state_nxt = ST_IDLE;
            end
         end

         ST_LOCKOUT: begin
            timer_nxt = timer_q + 32'd1;
            if (timer_q == LOCK_LAST) begin
               fail_nxt  = 2'd0;
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign state     = state_q;
   assign unlocked  = unlocked_q;
   assign lockout   = lockout_q;
   assign fail_cnt  = fail_q;
   assign ok_pulse  = ok_q;
   assign err_pulse = err_q;

endmodule

// File: tb/tb_pwd_lock_ctrl.sv
// Self-checking bench for pwd_lock_ctrl: directed scenarios followed by random traffic,
// compared every cycle against a deadline-based behavioural model of the lock.
module tb_pwd_lock_ctrl;

   localparam int OPEN_C = 8;
   localparam int LOCK_C = 16;
   localparam int MAX_T  = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] code_in = 12'd0;
   logic        code_valid = 1'b0;
   logic        change_req = 1'b0;
   logic [2:0]  state;
   logic        unlocked, lockout, ok_pulse, err_pulse;
   logic [1:0]  fail_cnt;

   int n_checks = 0;
   int n_errors = 0;

   pwd_lock_ctrl #(
      .DEFAULT_PWD (12'h123),
      .MAX_TRIES   (MAX_T),
      .OPEN_CYCLES (32'(OPEN_C)),
      .LOCK_CYCLES (32'(LOCK_C))
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .code_in    (code_in),
      .code_valid (code_valid),
      .change_req (change_req),
      .state      (state),
      .unlocked   (unlocked),
      .lockout    (lockout),
      .fail_cnt   (fail_cnt),
      .ok_pulse   (ok_pulse),
      .err_pulse  (err_pulse)
   );

   always #5 clock = ~clock;

   // Reference model: mode numbers follow the visible state encoding; time is
   // tracked as an absolute edge count at which the current mode expires.
   int          m_mode;
   logic [11:0] m_pwd, m_cand, m_code;
   int          m_fail;
   longint      cyc, m_deadline;
   bit          m_ok, m_err;

   function automatic bit bcd(input logic [11:0] c);
      return (c[11:8] < 10) && (c[7:4] < 10) && (c[3:0] < 10);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pwd = 12'h123; m_cand = 12'd0; m_code = 12'd0;
      m_fail = 0; m_ok = 0; m_err = 0; m_deadline = 0;
   endtask

   task automatic model_step(input bit cv, input logic [11:0] c, input bit chg);
      cyc++;
      m_ok = 0; m_err = 0;
      case (m_mode)
         0: if (cv) begin m_code = c; m_mode = 1; end
         1: begin
            if (bcd(m_code) && m_code == m_pwd) begin
               m_fail = 0; m_ok = 1; m_mode = 2; m_deadline = cyc + OPEN_C;
            end else begin
               m_err = 1;
               if (m_fail + 1 == MAX_T) begin
                  m_fail = MAX_T; m_mode = 3; m_deadline = cyc + LOCK_C;
               end else begin
                  m_fail++; m_mode = 0;
               end
            end
         end
         2: begin
            if (chg) begin m_mode = 4; m_deadline = cyc + OPEN_C; end
            else if (cyc == m_deadline) m_mode = 0;
         end
         3: if (cyc == m_deadline) begin m_mode = 0; m_fail = 0; end
         4: begin
            if (cv) begin
               if (bcd(c)) begin m_cand = c; m_mode = 5; m_deadline = cyc + OPEN_C; end
               else begin m_err = 1; m_mode = 0; end
            end else if (cyc == m_deadline) m_mode = 0;
         end
         5: begin
            if (cv) begin
               if (c == m_cand) begin m_pwd = m_cand; m_ok = 1; end
               else m_err = 1;
               m_mode = 0;
            end else if (cyc == m_deadline) m_mode = 0;
         end
         default: m_mode = 0;
      endcase
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("state", 32'(state), 32'(m_mode));
      check("unlocked", 32'(unlocked), 32'(m_mode == 2));
      check("lockout", 32'(lockout), 32'(m_mode == 3));
      check("fail_cnt", 32'(fail_cnt), 32'(m_fail));
      check("ok_pulse", 32'(ok_pulse), 32'(m_ok));
      check("err_pulse", 32'(err_pulse), 32'(m_err));
   endtask

   // Drive one cycle of inputs from a negedge, advance the model on the edge,
   // compare on the following negedge.
   task automatic cycle(input bit cv, input logic [11:0] c, input bit chg);
      code_valid = cv; code_in = c; change_req = chg;
      @(posedge clock);
      model_step(cv, c, chg);
      @(negedge clock);
      code_valid = 1'b0; change_req = 1'b0;
      compare_all();
   endtask

   task automatic open_with(input logic [11:0] c);
      cycle(1'b1, c, 1'b0);
      cycle(1'b0, 12'd0, 1'b0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 64 && m_mode != 0; i++) cycle(1'b0, 12'd0, 1'b0);
      if (m_mode != 0) check("wait_idle_timeout", 32'(m_mode), 32'd0);
   endtask

   initial begin
      int cnt;
      bit cv, chg;
      logic [11:0] c;
      cyc = 0;
      model_reset();

      // Reset state
      repeat (2) @(negedge clock);
      reset = 1'b0;
      compare_all();

      // Correct default code; unlocked window length
      cycle(1'b1, 12'h123, 1'b0);
      check("first_check_state", 32'(state), 32'd1);
      cycle(1'b0, 12'd0, 1'b0);
      check("open_state", 32'(state), 32'd2);
      check("open_ok", 32'(ok_pulse), 32'd1);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (unlocked) cnt++;
         cycle(1'b0, 12'd0, 1'b0);
      end
      check("unlocked_len", 32'(cnt), 32'(OPEN_C));
      check("after_open_state", 32'(state), 32'd0);

      // Three failures -> lockout; code ignored during lockout
      for (int i = 0; i < 3; i++) begin
         open_with(12'h999);
         check("wrong_fail_cnt", 32'(fail_cnt), 32'(i + 1));
         check("wrong_err", 32'(err_pulse), 32'd1);
      end
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (lockout) cnt++;
         cycle(i == 3, 12'h123, i == 5);
      end
      check("lockout_len", 32'(cnt), 32'(LOCK_C));
      check("post_lock_fail", 32'(fail_cnt), 32'd0);
      open_with(12'h123);
      check("post_lock_open", 32'(state), 32'd2);
      wait_idle();

      // Two failures then success clears the count
      open_with(12'h999);
      open_with(12'h998);
      check("two_fail", 32'(fail_cnt), 32'd2);
      open_with(12'h123);
      check("recover_fail", 32'(fail_cnt), 32'd0);
      check("recover_state", 32'(state), 32'd2);

      // Successful change to 456
      cycle(1'b0, 12'd0, 1'b1);
      check("new1_state", 32'(state), 32'd4);
      cycle(1'b1, 12'h456, 1'b0);
      check("new2_state", 32'(state), 32'd5);
      cycle(1'b1, 12'h456, 1'b0);
      check("commit_ok", 32'(ok_pulse), 32'd1);
      check("commit_idle", 32'(state), 32'd0);
      open_with(12'h123);
      check("old_pwd_rejected", 32'(err_pulse), 32'd1);
      open_with(12'h456);
      check("new_pwd_opens", 32'(state), 32'd2);

      // Rejected changes
      cycle(1'b0, 12'd0, 1'b1);
      cycle(1'b1, 12'h4A6, 1'b0);
      check("nonbcd_err", 32'(err_pulse), 32'd1);
      open_with(12'h456);
      cycle(1'b0, 12'd0, 1'b1);
      cycle(1'b1, 12'h456, 1'b0);
      cycle(1'b1, 12'h457, 1'b0);
      check("confirm_err", 32'(err_pulse), 32'd1);
      open_with(12'h456);
      cycle(1'b0, 12'd0, 1'b1);
      for (int i = 0; i < OPEN_C + 2; i++) cycle(1'b0, 12'd0, 1'b0);
      check("new1_timeout", 32'(state), 32'd0);
      open_with(12'h456);
      check("pwd_kept", 32'(state), 32'd2);

      // Commit 789, then reset while in NEW2 of a further change
      cycle(1'b0, 12'd0, 1'b1);
      cycle(1'b1, 12'h789, 1'b0);
      cycle(1'b1, 12'h789, 1'b0);
      open_with(12'h789);
      cycle(1'b0, 12'd0, 1'b1);
      cycle(1'b1, 12'h321, 1'b0);
      check("pre_reset_new2", 32'(state), 32'd5);
      #2 reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(negedge clock);
      reset = 1'b0;
      compare_all();
      // Back-to-back entries: the wrong code lands in CHECK and is dropped
      cycle(1'b1, 12'h123, 1'b0);
      cycle(1'b1, 12'h999, 1'b0);
      check("b2b_open", 32'(state), 32'd2);
      check("b2b_fail", 32'(fail_cnt), 32'd0);
      wait_idle();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cv  = ($urandom_range(0, 2) == 0);
         chg = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 3))
            0: c = m_pwd;
            1: c = m_cand;
            2: c = 12'($urandom);
            default: c = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         endcase
         cycle(cv, c, chg);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
